// File: rtl/jk_bank_arbiter_if.sv
// Request/response bundle for the JK bank arbiter.
// The requester side drives the commands and freeze; the bank side returns
// the grants, the bank contents and the response.
interface jk_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = $clog2(NREQ);

  logic                freeze;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*W-1:0]   req_j;
  logic [NREQ*W-1:0]   req_k;
  logic [NREQ-1:0]     req_ready;
  logic [W-1:0]        q;
  logic [W-1:0]        qnot;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_q;

  modport master (
    output freeze, req_valid, req_j, req_k,
    input  req_ready, q, qnot, rsp_valid, rsp_id, rsp_q
  );

  modport slave (
    input  freeze, req_valid, req_j, req_k,
    output req_ready, q, qnot, rsp_valid, rsp_id, rsp_q
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Bank of W JK flip-flops shared by NREQ requesters through a round-robin
// arbiter. One command is granted per cycle; it lands on q at the next edge
// together with a one-cycle response carrying the served id and new state.
module jk_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  jk_bank_arbiter_if.slave   bus
);

  logic [IDW-1:0] rr_ptr_p1;
  logic           grant_vld_p0;
  logic [IDW-1:0] grant_id_p0;
  logic           accept_p0;
  logic [IDW:0]   arb_sum;
  logic [IDW-1:0] arb_idx;
  logic [W-1:0]   sel_j_p0;
  logic [W-1:0]   sel_k_p0;
  logic [W-1:0]   q_next_p0;
  logic [IDW-1:0] ptr_next_p0;

  logic [W-1:0]   q_p1;
  logic           vld_p1;
  logic [IDW-1:0] rsp_id_p1;
  logic [W-1:0]   rsp_q_p1;

  // Per-bit JK next state: J sets a cleared bit, ~K keeps a set bit.
  function automatic logic [W-1:0] jk_apply(input logic [W-1:0] q_cur,
                                            input logic [W-1:0] j,
                                            input logic [W-1:0] k);
    return (j & ~q_cur) | (~k & q_cur);
  endfunction

  // ---- stage p0: arbitration, command select, JK evaluation ----

  // Search from rr_ptr upward, wrapping modulo NREQ; first valid wins.
  always_comb begin
    grant_vld_p0 = 1'b0;
    grant_id_p0  = '0;
    arb_sum      = '0;
    arb_idx      = '0;
    for (int n = 0; n < NREQ; n++) begin
      arb_sum = {1'b0, rr_ptr_p1} + (IDW+1)'(n);
      if (arb_sum >= (IDW+1)'(NREQ)) arb_sum = arb_sum - (IDW+1)'(NREQ);
      arb_idx = arb_sum[IDW-1:0];
      if (!grant_vld_p0 && bus.req_valid[arb_idx]) begin
        grant_vld_p0 = 1'b1;
        grant_id_p0  = arb_idx;
      end
    end
  end

  // Reset and freeze both suppress the grant in the same cycle.
  assign accept_p0 = grant_vld_p0 & ~bus.freeze & ~reset;

  // One-hot ready for the winner, all zero when nothing is accepted.
  always_comb begin
    bus.req_ready = '0;
    if (accept_p0) bus.req_ready[grant_id_p0] = 1'b1;
  end

  // Pick the winner's J/K slice out of the packed request vectors.
  always_comb begin
    sel_j_p0 = '0;
    sel_k_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_p0 == IDW'(i)) begin
        sel_j_p0 = bus.req_j[i*W +: W];
        sel_k_p0 = bus.req_k[i*W +: W];
      end
    end
  end

  assign q_next_p0   = jk_apply(q_p1, sel_j_p0, sel_k_p0);
  assign ptr_next_p0 = (grant_id_p0 == IDW'(NREQ-1)) ? '0 : grant_id_p0 + 1'b1;

  // ---- stage p1: bank state, pointer and response registers ----

  // Apply the accepted command; otherwise hold state and drop the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_p1      <= '0;
      rr_ptr_p1 <= '0;
      vld_p1    <= 1'b0;
      rsp_id_p1 <= '0;
      rsp_q_p1  <= '0;
    end else begin
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        q_p1      <= q_next_p0;
        rr_ptr_p1 <= ptr_next_p0;
        rsp_id_p1 <= grant_id_p0;
        rsp_q_p1  <= q_next_p0;
      end
    end
  end

  assign bus.q         = q_p1;
  assign bus.qnot      = ~q_p1;
  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_id    = rsp_id_p1;
  assign bus.rsp_q     = rsp_q_p1;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Testbench for jk_bank_arbiter: directed scenarios plus a randomized run,
// all checked against a behavioural model of the arbiter and JK bank.
module tb_jk_bank_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = $clog2(NREQ);
  localparam int OW   = NREQ + 3*W + 1 + IDW;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  jk_bank_arbiter_if #(.NREQ(NREQ), .W(W)) bus();

  jk_bank_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [W-1:0]   m_q   = '0;
  int             m_ptr = 0;
  logic           m_rv  = 1'b0;
  logic [IDW-1:0] m_rid = '0;
  logic [W-1:0]   m_rq  = '0;
  int             last_grant = -1;

  function automatic int m_winner();
    int idx;
    for (int n = 0; n < NREQ; n++) begin
      idx = (m_ptr + n) % NREQ;
      if (bus.req_valid[idx] === 1'b1) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    int w;
    w = m_winner();
    if (reset || bus.freeze || w < 0) return '0;
    return NREQ'(1) << w;
  endfunction

  function automatic logic [W-1:0] m_jk(input logic [W-1:0] q, input logic [W-1:0] j,
                                        input logic [W-1:0] k);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) begin
      case ({j[b], k[b]})
        2'b00:   r[b] = q[b];
        2'b01:   r[b] = 1'b0;
        2'b10:   r[b] = 1'b1;
        default: r[b] = ~q[b];
      endcase
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] m_obs();
    return {m_ready(), m_q, ~m_q, m_rv, m_rid, m_rq};
  endfunction

  function automatic logic [OW-1:0] dut_obs();
    return {bus.req_ready, bus.q, bus.qnot, bus.rsp_valid, bus.rsp_id, bus.rsp_q};
  endfunction

  // Advance one clock and move the model across the same edge.
  task automatic tick();
    int w;
    logic acc;
    logic [W-1:0] j, k, nq;
    w   = m_winner();
    acc = !reset && !bus.freeze && (w >= 0);
    j   = '0;
    k   = '0;
    if (w >= 0) begin
      j = bus.req_j[w*W +: W];
      k = bus.req_k[w*W +: W];
    end
    last_grant = acc ? w : -1;
    @(posedge clk);
    if (reset) begin
      m_q = '0; m_ptr = 0; m_rv = 1'b0; m_rid = '0; m_rq = '0;
    end else if (acc) begin
      nq    = m_jk(m_q, j, k);
      m_q   = nq;
      m_ptr = (w + 1) % NREQ;
      m_rv  = 1'b1;
      m_rid = IDW'(w);
      m_rq  = nq;
    end else begin
      m_rv = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [OW-1:0] got;
    reset         = 1'b1;
    bus.freeze    = 1'b0;
    bus.req_valid = '1;
    bus.req_j     = {$urandom, $urandom};
    bus.req_k     = {$urandom, $urandom};
    #1;
    n_cmp++;
    if (bus.req_ready !== '0) begin
      n_bad++; $display("FAIL reset_ready_pre got=%b exp=%b", bus.req_ready, 4'b0000);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      got = dut_obs();
      n_cmp++;
      if (got !== m_obs()) begin
        n_bad++; $display("FAIL reset_obs c=%0d got=%h exp=%h", c, got, m_obs());
      end
      n_cmp++;
      if ({bus.req_ready, bus.q, bus.qnot, bus.rsp_valid} !== {4'b0000, 8'h00, 8'hFF, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_const c=%0d got=%b/%h/%h/%b exp=0000/00/ff/0", c,
                 bus.req_ready, bus.q, bus.qnot, bus.rsp_valid);
      end
    end
    reset         = 1'b0;
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    logic [W-1:0] jv[4] = '{8'hF0, 8'hFF, 8'h00, 8'h00};
    logic [W-1:0] kv[4] = '{8'h00, 8'hFF, 8'h0F, 8'h00};
    logic [W-1:0] ev[4] = '{8'hF0, 8'h0F, 8'h00, 8'h00};
    logic [OW-1:0] got;
    bus.req_valid = 4'b0100;
    for (int s = 0; s < 4; s++) begin
      bus.req_j = '0;
      bus.req_k = '0;
      bus.req_j[2*W +: W] = jv[s];
      bus.req_k[2*W +: W] = kv[s];
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0100) begin
        n_bad++; $display("FAIL single_ready s=%0d got=%b exp=0100", s, bus.req_ready);
      end
      tick();
      n_cmp++;
      if ({bus.q, bus.rsp_valid, bus.rsp_id, bus.rsp_q} !== {ev[s], 1'b1, 2'd2, ev[s]}) begin
        n_bad++;
        $display("FAIL single_op s=%0d got q=%h v=%b id=%0d rq=%h exp q=%h v=1 id=2 rq=%h",
                 s, bus.q, bus.rsp_valid, bus.rsp_id, bus.rsp_q, ev[s], ev[s]);
      end
      got = dut_obs();
      n_cmp++;
      if (got !== m_obs()) begin
        n_bad++; $display("FAIL single_obs s=%0d got=%h exp=%h", s, got, m_obs());
      end
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [OW-1:0] got;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_j[i*W +: W] = W'(1) << i;
      bus.req_k[i*W +: W] = '0;
    end
    for (int c = 0; c < 8; c++) begin
      #1;
      n_cmp++;
      if (bus.req_ready !== (4'b0001 << (c % 4))) begin
        n_bad++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, bus.req_ready, 4'b0001 << (c % 4));
      end
      got = dut_obs();
      n_cmp++;
      if (got !== m_obs()) begin
        n_bad++; $display("FAIL rr_obs c=%0d got=%h exp=%h", c, got, m_obs());
      end
      tick();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(c % 4)) begin
        n_bad++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d exp v=1 id=%0d", c, bus.rsp_valid, bus.rsp_id, c % 4);
      end
    end
    n_cmp++;
    if (bus.q !== 8'h0F) begin
      n_bad++; $display("FAIL rr_q got=%h exp=0f", bus.q);
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_skip_wrap();
    logic [NREQ-1:0] vseq[6] = '{4'b1000, 4'b0110, 4'b0110, 4'b1000, 4'b0001, 4'b0000};
    logic [NREQ-1:0] rseq[6] = '{4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    logic [OW-1:0] got;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_j[i*W +: W] = W'($urandom);
      bus.req_k[i*W +: W] = W'($urandom);
    end
    for (int s = 0; s < 6; s++) begin
      bus.req_valid = vseq[s];
      #1;
      n_cmp++;
      if (bus.req_ready !== rseq[s]) begin
        n_bad++; $display("FAIL skip_ready s=%0d got=%b exp=%b", s, bus.req_ready, rseq[s]);
      end
      got = dut_obs();
      n_cmp++;
      if (got !== m_obs()) begin
        n_bad++; $display("FAIL skip_obs s=%0d got=%h exp=%h", s, got, m_obs());
      end
      tick();
    end
  endtask

  task automatic test_freeze();
    logic [W-1:0] q_hold;
    logic [OW-1:0] got;
    bus.req_valid = 4'b0010;
    tick();
    q_hold        = m_q;
    bus.req_valid = '1;
    bus.freeze    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if ({bus.req_ready, bus.q, bus.rsp_valid} !== {4'b0000, q_hold, (c == 0)}) begin
        n_bad++;
        $display("FAIL freeze c=%0d got rdy=%b q=%h v=%b exp rdy=0000 q=%h v=%b", c,
                 bus.req_ready, bus.q, bus.rsp_valid, q_hold, (c == 0));
      end
      got = dut_obs();
      n_cmp++;
      if (got !== m_obs()) begin
        n_bad++; $display("FAIL freeze_obs c=%0d got=%h exp=%h", c, got, m_obs());
      end
      tick();
    end
    bus.freeze = 1'b0;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0100) begin
      n_bad++; $display("FAIL freeze_resume got=%b exp=0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_reset_midstream();
    logic [OW-1:0] got;
    bus.req_j = '0;
    bus.req_k = '0;
    bus.req_j[W-1:0] = 8'hFF;
    bus.req_k[W-1:0] = 8'hFF;
    bus.req_valid    = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      got = dut_obs();
      n_cmp++;
      if (got !== m_obs()) begin
        n_bad++; $display("FAIL mid_pre_obs c=%0d got=%h exp=%h", c, got, m_obs());
      end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0000) begin
      n_bad++; $display("FAIL mid_reset_ready got=%b exp=0000", bus.req_ready);
    end
    tick();
    reset = 1'b0;
    n_cmp++;
    if (bus.q !== 8'h00 || bus.rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_state got q=%h v=%b exp q=00 v=0", bus.q, bus.rsp_valid);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (bus.q !== ((c % 2 == 0) ? 8'hFF : 8'h00)) begin
        n_bad++; $display("FAIL mid_toggle c=%0d got=%h exp=%h", c, bus.q, (c % 2 == 0) ? 8'hFF : 8'h00);
      end
      got = dut_obs();
      n_cmp++;
      if (got !== m_obs()) begin
        n_bad++; $display("FAIL mid_obs c=%0d got=%h exp=%h", c, got, m_obs());
      end
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [OW-1:0] got;
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = NREQ'($urandom);
      bus.req_j     = {$urandom, $urandom};
      bus.req_k     = {$urandom, $urandom};
      bus.freeze    = ($urandom_range(0, 9) == 0);
      reset         = ($urandom_range(0, 39) == 0);
      #1;
      got = dut_obs();
      n_cmp++;
      if (got !== m_obs()) begin
        n_bad++; $display("FAIL random_obs c=%0d got=%h exp=%h", c, got, m_obs());
      end
      tick();
    end
    reset      = 1'b0;
    bus.freeze = 1'b0;
    #1;
    got = dut_obs();
    n_cmp++;
    if (got !== m_obs()) begin
      n_bad++; $display("FAIL random_final got=%h exp=%h", got, m_obs());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip_wrap();
    test_freeze();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
